// File: rtl/humidity_pkg.sv
// Shared types and widths for the soil-humidity scan controller.
// Holds the scan FSM encoding, datapath widths and the dry-flag hysteresis rule.
package humidity_pkg;

    localparam int VOLT_W         = 12;
    localparam int HUM_W          = 10;
    localparam int ACC_W          = 12;
    localparam int SAMPLES_PER_CH = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_ADC = 3'd2,
        ST_CONV     = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_PUBLISH  = 3'd5
    } scan_state_e;

    // Release threshold is widened by one bit so thresh + hyst cannot wrap.
    function automatic logic dry_next(
        input logic             cur,
        input logic [HUM_W-1:0] hum,
        input logic [HUM_W-1:0] thresh,
        input logic [HUM_W:0]   hyst
    );
        logic [HUM_W:0] release_lvl;
        release_lvl = {1'b0, thresh} + hyst;
        if (hum < thresh) begin
            dry_next = 1'b1;
        end else if ({1'b0, hum} >= release_lvl) begin
            dry_next = 1'b0;
        end else begin
            dry_next = cur;
        end
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan period counter: one-cycle tick every SCAN_PERIOD clocks
// while enabled, held at zero while disabled.
module scan_tick_gen #(
    parameter int SCAN_PERIOD = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_PERIOD - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Period counter and registered tick pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else if (!enable) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/humidity_scan_ctrl.sv
// Periodic multi-channel soil-humidity scanner: requests ADC samples, converts
// them through the shared converter, averages four per channel and flags dry soil.
module humidity_scan_ctrl
    import humidity_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SCAN_PERIOD = 50_000_000,
    parameter int ADC_TIMEOUT = 1024,
    parameter int HYST        = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              adc_start,
    output logic [1:0]        adc_chan,
    input  logic              adc_done,
    input  logic [VOLT_W-1:0] adc_data,
    output logic [VOLT_W-1:0] conv_voltage,
    input  logic [HUM_W-1:0]  conv_humidity,
    input  logic [HUM_W-1:0]  dry_thresh,
    output logic              hum_valid,
    output logic [1:0]        hum_chan,
    output logic [HUM_W-1:0]  hum_value,
    output logic [NUM_CH-1:0] dry_flags,
    output logic [NUM_CH-1:0] adc_err,
    output logic              busy
);

    localparam int              TO_W     = $clog2(ADC_TIMEOUT + 1);
    localparam logic [TO_W-1:0] LAST_TO  = TO_W'(ADC_TIMEOUT - 1);
    localparam logic [1:0]      LAST_CH  = 2'(NUM_CH - 1);
    localparam logic [1:0]      LAST_IDX = 2'(SAMPLES_PER_CH - 1);
    localparam logic [HUM_W:0]  HYST_C   = (HUM_W + 1)'(HYST);

    scan_state_e        state_r;
    scan_state_e        state_nxt;
    logic               tick_s;
    logic               timeout_s;
    logic               abort_s;
    logic               last_ch_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic [1:0]         ch_r;
    logic [1:0]         idx_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic [ACC_W-1:0]   acc_r;
    logic               abort_r;
    logic               busy_r;
    logic               adc_start_r;
    logic               hum_valid_r;
    logic [1:0]         hum_chan_r;
    logic [HUM_W-1:0]   hum_value_r;
    logic [VOLT_W-1:0]  conv_voltage_r;
    logic [NUM_CH-1:0]  dry_flags_r;
    logic [NUM_CH-1:0]  adc_err_r;

    scan_tick_gen #(
        .SCAN_PERIOD(SCAN_PERIOD)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick_s)
    );

    // Once enable drops mid-scan, the in-flight conversion still completes but is discarded.
    assign abort_s   = abort_r | ~enable;
    assign timeout_s = (to_cnt_r == LAST_TO);
    assign last_ch_s = (ch_r == LAST_CH);
    assign acc_sum_s = acc_r + {{(ACC_W - HUM_W){1'b0}}, conv_humidity};

    // Next-state decode for the scan sequencer.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s && enable) state_nxt = ST_START;
                else                  state_nxt = ST_IDLE;
            end
            ST_START: begin
                state_nxt = ST_WAIT_ADC;
            end
            ST_WAIT_ADC: begin
                if (adc_done || timeout_s) begin
                    if (abort_s)        state_nxt = ST_IDLE;
                    else if (adc_done)  state_nxt = ST_CONV;
                    else if (last_ch_s) state_nxt = ST_IDLE;
                    else                state_nxt = ST_START;
                end else begin
                    state_nxt = ST_WAIT_ADC;
                end
            end
            ST_CONV: begin
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort_s)                state_nxt = ST_IDLE;
                else if (idx_r == LAST_IDX) state_nxt = ST_PUBLISH;
                else                        state_nxt = ST_START;
            end
            ST_PUBLISH: begin
                if (abort_s || last_ch_s) state_nxt = ST_IDLE;
                else                      state_nxt = ST_START;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            ch_r           <= 2'd0;
            idx_r          <= 2'd0;
            to_cnt_r       <= {TO_W{1'b0}};
            acc_r          <= {ACC_W{1'b0}};
            abort_r        <= 1'b0;
            busy_r         <= 1'b0;
            adc_start_r    <= 1'b0;
            hum_valid_r    <= 1'b0;
            hum_chan_r     <= 2'd0;
            hum_value_r    <= {HUM_W{1'b0}};
            conv_voltage_r <= {VOLT_W{1'b0}};
            dry_flags_r    <= {NUM_CH{1'b0}};
            adc_err_r      <= {NUM_CH{1'b0}};
        end else begin
            state_r     <= state_nxt;
            busy_r      <= (state_nxt != ST_IDLE);
            adc_start_r <= (state_nxt == ST_START);
            hum_valid_r <= (state_nxt == ST_PUBLISH);
            to_cnt_r    <= (state_r == ST_WAIT_ADC) ? to_cnt_r + TO_W'(1) : {TO_W{1'b0}};

            if (state_nxt == ST_IDLE) abort_r <= 1'b0;
            else if (!enable)         abort_r <= 1'b1;
            else                      abort_r <= abort_r;

            case (state_r)
                ST_IDLE: begin
                    if (state_nxt == ST_START) begin
                        ch_r  <= 2'd0;
                        idx_r <= 2'd0;
                        acc_r <= {ACC_W{1'b0}};
                    end
                end
                ST_WAIT_ADC: begin
                    if (adc_done) begin
                        conv_voltage_r <= adc_data;
                    end else if (timeout_s) begin
                        adc_err_r[ch_r] <= 1'b1;
                        acc_r           <= {ACC_W{1'b0}};
                        idx_r           <= 2'd0;
                        if (!last_ch_s && !abort_s) ch_r <= ch_r + 2'd1;
                    end
                end
                ST_CAPTURE: begin
                    acc_r <= acc_sum_s;
                    idx_r <= idx_r + 2'd1;
                    if (state_nxt == ST_PUBLISH) begin
                        hum_value_r <= acc_sum_s[ACC_W-1 -: HUM_W];
                        hum_chan_r  <= ch_r;
                    end
                end
                ST_PUBLISH: begin
                    dry_flags_r[ch_r] <= dry_next(dry_flags_r[ch_r], hum_value_r, dry_thresh, HYST_C);
                    adc_err_r[ch_r]   <= 1'b0;
                    acc_r             <= {ACC_W{1'b0}};
                    idx_r             <= 2'd0;
                    if (!last_ch_s && !abort_s) ch_r <= ch_r + 2'd1;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign adc_start    = adc_start_r;
    assign adc_chan     = ch_r;
    assign conv_voltage = conv_voltage_r;
    assign hum_valid    = hum_valid_r;
    assign hum_chan     = hum_chan_r;
    assign hum_value    = hum_value_r;
    assign dry_flags    = dry_flags_r;
    assign adc_err      = adc_err_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_humidity_scan_ctrl.sv
// Directed bench for humidity_scan_ctrl with ADC and converter models and a
// scoreboard of expected averaged results.
module tb_humidity_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        adc_start;
    logic [1:0]  adc_chan;
    logic        adc_done = 1'b0;
    logic [11:0] adc_data = 12'd0;
    logic [11:0] conv_voltage;
    logic [9:0]  conv_humidity = 10'd0;
    logic [9:0]  dry_thresh;
    logic        hum_valid;
    logic [1:0]  hum_chan;
    logic [9:0]  hum_value;
    logic [3:0]  dry_flags;
    logic [3:0]  adc_err;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    logic [11:0] adc_q[$];
    logic [11:0] mon_e;
    int          mute_ch = -1;
    logic        spur_req = 1'b0;
    int          adc_cnt = 0;

    humidity_scan_ctrl #(
        .NUM_CH(4), .SCAN_PERIOD(100), .ADC_TIMEOUT(1024), .HYST(20)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .adc_start(adc_start), .adc_chan(adc_chan),
        .adc_done(adc_done), .adc_data(adc_data),
        .conv_voltage(conv_voltage), .conv_humidity(conv_humidity),
        .dry_thresh(dry_thresh),
        .hum_valid(hum_valid), .hum_chan(hum_chan), .hum_value(hum_value),
        .dry_flags(dry_flags), .adc_err(adc_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // ADC: answers a request 5 cycles later; one channel can be muted.
    always @(negedge clk) begin
        adc_done = 1'b0;
        if (rst) begin
            adc_cnt = 0;
        end else if (spur_req) begin
            adc_done = 1'b1;
            adc_data = 12'h123;
            spur_req = 1'b0;
        end else if (adc_cnt == 1) begin
            adc_cnt  = 0;
            adc_done = 1'b1;
            if (adc_q.size() > 0) adc_data = adc_q.pop_front();
            else                  adc_data = 12'h83E;
        end else if (adc_cnt > 1) begin
            adc_cnt = adc_cnt - 1;
        end else if (adc_start && int'(adc_chan) != mute_ch) begin
            adc_cnt = 5;
        end
    end

    // Converter: registered, 0x83E maps to 50, anything else passes its low 10 bits.
    always @(posedge clk) begin
        conv_humidity <= (conv_voltage == 12'h83E) ? 10'd50 : conv_voltage[9:0];
    end

    // Scoreboard: every strobe must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && hum_valid) begin
            n_vec = n_vec + 1;
            assert (exp_q.size() > 0) else begin
                n_err = n_err + 1;
                $error("FAIL unexpected_strobe observed chan=%0d value=%0d expected no strobe", hum_chan, hum_value);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                assert ({hum_chan, hum_value} === mon_e) else begin
                    n_err = n_err + 1;
                    $error("FAIL hum_result observed chan=%0d value=%0d expected chan=%0d value=%0d",
                           hum_chan, hum_value, mon_e[11:10], mon_e[9:0]);
                end
            end
        end
    end

    task automatic tick_n();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input logic level, input int limit, input string tag);
        int c = 0;
        while (busy !== level && c < limit) begin
            tick_n();
            c++;
        end
        check(tag, 16'(busy), 16'(level));
    endtask

    task automatic wait_start_on(input logic [1:0] ch, input int limit, input string tag);
        int c = 0;
        while (!(adc_start === 1'b1 && adc_chan === ch) && c < limit) begin
            tick_n();
            c++;
        end
        check(tag, 16'(adc_chan), 16'(ch));
    endtask

    task automatic wait_done(input int limit, input string tag);
        int c = 0;
        while (adc_done !== 1'b1 && c < limit) begin
            tick_n();
            c++;
        end
        check(tag, 16'(adc_done), 16'd1);
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [9:0] val);
        exp_q.push_back({ch, val});
    endtask

    task automatic run_scan(input string tag);
        enable = 1'b1;
        wait_busy(1'b1, 150, {tag, "_start"});
        wait_busy(1'b0, 3000, {tag, "_end"});
        enable = 1'b0;
    endtask

    initial begin
        logic [9:0] avg_tab [3];
        logic [3:0] flag_tab [3];
        int         c;
        avg_tab  = '{10'd290, 10'd310, 10'd320};
        flag_tab = '{4'b1111, 4'b1111, 4'b1101};

        rst        = 1'b1;
        enable     = 1'b0;
        dry_thresh = 10'd0;
        repeat (3) tick_n();
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_adc_start", 16'(adc_start), 16'd0);
        check("rst_hum_valid", 16'(hum_valid), 16'd0);
        check("rst_flags", 16'({dry_flags, adc_err}), 16'd0);
        rst = 1'b0;

        // Spurious adc_done while idle must be ignored.
        spur_req = 1'b1;
        repeat (4) tick_n();
        check("spur_busy", 16'(busy), 16'd0);
        check("spur_conv_voltage", 16'(conv_voltage), 16'd0);

        // Nominal scan; a tick lands mid-scan and must not queue another.
        for (int ch = 0; ch < 4; ch++) push_exp(2'(ch), 10'd50);
        run_scan("scan_basic");
        repeat (3) tick_n();
        check("no_extra_scan", 16'(busy), 16'd0);
        check("basic_flags", 16'(dry_flags), 16'd0);
        check("basic_err", 16'(adc_err), 16'd0);
        check("basic_count", 16'(exp_q.size()), 16'd0);

        // Truncating average: 0+5+10+14 = 29 -> 7.
        adc_q.push_back(12'd0);
        adc_q.push_back(12'd5);
        adc_q.push_back(12'd10);
        adc_q.push_back(12'd14);
        push_exp(2'd0, 10'd7);
        for (int ch = 1; ch < 4; ch++) push_exp(2'(ch), 10'd50);
        run_scan("scan_trunc");
        check("trunc_count", 16'(exp_q.size()), 16'd0);

        // Dry flag hysteresis on channel 1.
        dry_thresh = 10'd300;
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 4; s++) adc_q.push_back(12'h83E);
            for (int s = 0; s < 4; s++) adc_q.push_back({2'b00, avg_tab[k]});
            push_exp(2'd0, 10'd50);
            push_exp(2'd1, avg_tab[k]);
            push_exp(2'd2, 10'd50);
            push_exp(2'd3, 10'd50);
            run_scan("scan_dry");
            check("dry_flags", 16'(dry_flags), 16'(flag_tab[k]));
        end

        // Silent ADC on channel 2: timeout, skip, channel 3 still published.
        dry_thresh = 10'd0;
        mute_ch    = 2;
        push_exp(2'd0, 10'd50);
        push_exp(2'd1, 10'd50);
        push_exp(2'd3, 10'd50);
        enable = 1'b1;
        wait_busy(1'b1, 150, "tmo_start");
        wait_start_on(2'd2, 300, "tmo_req_ch2");
        c = 0;
        while (adc_err[2] !== 1'b1 && c < 1100) begin
            tick_n();
            c++;
        end
        check("tmo_latency", 16'(c), 16'd1025);
        wait_busy(1'b0, 200, "tmo_end");
        enable  = 1'b0;
        mute_ch = -1;
        check("tmo_err", 16'(adc_err), 16'b0100);
        check("tmo_flag_hold", 16'(dry_flags), 16'b0100);
        check("tmo_count", 16'(exp_q.size()), 16'd0);

        // A clean scan clears the sticky timeout flag.
        for (int ch = 0; ch < 4; ch++) push_exp(2'(ch), 10'd50);
        run_scan("scan_recover");
        check("recover_err", 16'(adc_err), 16'd0);
        check("recover_flags", 16'(dry_flags), 16'd0);

        // Enable dropped while waiting on channel 1.
        dry_thresh = 10'd300;
        push_exp(2'd0, 10'd50);
        enable = 1'b1;
        wait_busy(1'b1, 150, "abort_start");
        wait_start_on(2'd1, 300, "abort_req_ch1");
        tick_n();
        enable = 1'b0;
        wait_done(20, "abort_done");
        tick_n();
        check("abort_idle", 16'(busy), 16'd0);
        repeat (20) tick_n();
        check("abort_stays_idle", 16'(busy), 16'd0);
        check("abort_flags", 16'(dry_flags), 16'b0001);
        check("abort_count", 16'(exp_q.size()), 16'd0);

        // Reset during CAPTURE clears everything on the next cycle.
        dry_thresh = 10'd0;
        enable     = 1'b1;
        wait_busy(1'b1, 150, "rst_mid_start");
        wait_done(50, "rst_mid_done");
        tick_n();
        tick_n();
        rst    = 1'b1;
        enable = 1'b0;
        tick_n();
        check("rstmid_busy", 16'(busy), 16'd0);
        check("rstmid_adc", 16'({adc_start, adc_chan}), 16'd0);
        check("rstmid_conv", 16'(conv_voltage), 16'd0);
        check("rstmid_hum", 16'({hum_valid, hum_chan, hum_value}), 16'd0);
        check("rstmid_flags", 16'({dry_flags, adc_err}), 16'd0);
        rst = 1'b0;
        repeat (5) tick_n();
        check("final_count", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/humidity_scan_ctrl.md
HUMIDITY_SCAN_CTRL -- requirements
Module: humidity_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of soil-humidity channels scanned.
REQ-002 SHALL have parameter SCAN_PERIOD, default 50_000_000: clk cycles between scan starts.
REQ-003 SHALL have parameter ADC_TIMEOUT, default 1024: max clk cycles to wait for adc_done.
REQ-004 SHALL have parameter HYST, default 20: dry-flag release hysteresis, in 0.1 %RH units.
REQ-005 SHALL have port clk, input, 1: single clock.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1: scanning permitted.
REQ-008 SHALL have port adc_start, output, 1: one-cycle conversion request.
REQ-009 SHALL have port adc_chan, output, 2: channel for the current request.
REQ-010 SHALL have port adc_done, input, 1: one-cycle pulse; adc_data is valid in that cycle.
REQ-011 SHALL have port adc_data, input, 12: raw sample.
REQ-012 SHALL have port conv_voltage, output, 12: drives the shared voltage-to-humidity converter.
REQ-013 SHALL have port conv_humidity, input, 10: converter result, registered, 1-cycle latency.
REQ-014 SHALL have port dry_thresh, input, 10: dry limit in 0.1 %RH.
REQ-015 SHALL have ports hum_valid, output, 1; hum_chan, output, 2; hum_value, output, 10: averaged result strobe, channel and value.
REQ-016 SHALL have ports dry_flags, output, NUM_CH; adc_err, output, NUM_CH (sticky timeout flags); busy, output, 1.

Function
REQ-017 SHALL use a free-running period counter that pulses a tick every SCAN_PERIOD cycles while enable=1 and is held at 0 while enable=0.
REQ-018 SHALL implement states IDLE, START, WAIT_ADC, CONV, CAPTURE, PUBLISH.
REQ-019 SHALL move IDLE->START on a tick, setting the channel to 0 and the sample index to 0; busy=1 in every state except IDLE.
REQ-020 SHALL, in START, assert adc_start for exactly one cycle with adc_chan set to the current channel, then enter WAIT_ADC.
REQ-021 SHALL, in WAIT_ADC, load conv_voltage from adc_data on adc_done and enter CONV; the converter samples conv_voltage during CONV.
REQ-022 SHALL, in CAPTURE (2 cycles after adc_done), add conv_humidity into a 12-bit accumulator; conv_voltage SHALL stay stable from load through CAPTURE.
REQ-023 SHALL take 4 samples per channel (CAPTURE->START while index<3); after the 4th sample it SHALL enter PUBLISH.
REQ-024 SHALL, in PUBLISH, drive hum_value=accumulator>>2 (truncated), hum_chan=channel and hum_valid=1 for exactly one cycle.
REQ-025 SHALL, in PUBLISH, clear the accumulator and advance the channel; after channel NUM_CH-1 it SHALL return to IDLE.
REQ-026 SHALL, in PUBLISH, set dry_flags[ch] when hum_value<dry_thresh and clear it when hum_value>=dry_thresh+HYST (11-bit compare, no wrap); otherwise the flag SHALL hold.
REQ-027 SHALL, on an ADC_TIMEOUT expiry in WAIT_ADC, set adc_err[ch], discard the channel's partial sum, skip PUBLISH for that channel and advance to the next channel; dry_flags[ch] SHALL hold.
REQ-028 SHALL ignore adc_done outside WAIT_ADC.
REQ-029 SHALL ignore ticks arriving while busy=1; no scan is queued.
REQ-030 SHALL, if enable falls mid-scan, finish only the in-flight conversion (adc_done or timeout), discard it, return to IDLE without hum_valid, and keep dry_flags.
REQ-031 SHALL clear adc_err[ch] on the next successful PUBLISH of that channel.

Reset
REQ-032 SHALL, on rst=1 at a clk edge, set state=IDLE and clear all counters, the accumulator, conv_voltage, hum_value, hum_chan, hum_valid, adc_start, adc_chan, dry_flags, adc_err and busy, overriding any operation in progress.

Structure
REQ-033 SHALL take the state enum, the width constants (12-bit voltage, 10-bit humidity, 12-bit accumulator) and the samples-per-channel constant from the shared package humidity_pkg.
REQ-034 SHALL implement the period counter as sub-module scan_tick_gen (ports clk, rst, enable, tick); all other logic is in this module.

Verification
REQ-035 SHALL cover: SCAN_PERIOD=100; ADC model with a 5-cycle delay returning 0x83E; converter model 0x83E->50 -> 4 hum_valid pulses, chans 0..3, value 50, busy low afterwards.
REQ-036 SHALL cover: samples 0, 5, 10, 14 on chan 0 (sum 29) -> hum_value 7 (truncated).
REQ-037 SHALL cover: dry_thresh=300; chan 1 averages 290, then 310, then 320 -> dry_flags[1] = 1, 1, 0.
REQ-038 SHALL cover: ADC silent on chan 2 -> adc_err[2]=1 after 1024 cycles, no hum_valid for chan 2, chan 3 still published.
REQ-039 SHALL cover: enable dropped during WAIT_ADC on chan 1 -> no further hum_valid and IDLE within 1 cycle of adc_done; rst asserted mid-CAPTURE -> all outputs 0 on the next cycle.
REQ-040 SHALL cover: spurious adc_done in IDLE, and a tick while busy -> no state change and no extra scan.
